turn_scheduler: RTL and testbench

Game-turn controller that sequences a tick prescaler and a per-turn seconds countdown, handing the move between NUM_PLAYERS players in round-robin order. Sits between the game logic (move_done, game_over) and the display/score logic, which consume player, secs_left and timeout. Replaces ad-hoc free-running counters with one controlled, restartable timer.

---
 rtl/turn_pkg.sv | 20 ++
 rtl/turn_scheduler_if.sv | 34 +++
 rtl/tick_gen.sv | 36 +++
 rtl/turn_scheduler.sv | 114 +++++++++++
 tb/tb_turn_scheduler.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/turn_pkg.sv
// Shared types and width helpers for the turn scheduler.
package turn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    SWITCH = 2'd2,
    DONE   = 2'd3
  } turn_state_t;

  // Player index is at least one bit wide even for two players.
  function automatic int player_w(input int num_players);
    return (num_players <= 2) ? 1 : $clog2(num_players);
  endfunction

  function automatic int secs_w(input int turn_secs);
    return $clog2(turn_secs + 1);
  endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// Game-logic <-> scheduler signal bundle. The pause input exists only when PAUSE_EN is defined.
interface turn_scheduler_if #(
  parameter int PW = 1,
  parameter int SW = 4
);
  import turn_pkg::*;

  // No valid/ready handshake: start is a level, move_done is a one-cycle pulse,
  // game_over is a level; every output is registered and valid on every cycle.
  logic          start;
  logic          move_done;
  logic          game_over;
`ifdef PAUSE_EN
  logic          pause;
`endif
  logic [PW-1:0] player;
  logic [SW-1:0] secs_left;
  logic          timeout;
  logic          active;
  turn_state_t   state;

`ifdef PAUSE_EN
  modport master (output start, move_done, game_over, pause,
                  input  player, secs_left, timeout, active, state);
  modport slave  (input  start, move_done, game_over, pause,
                  output player, secs_left, timeout, active, state);
`else
  modport master (output start, move_done, game_over,
                  input  player, secs_left, timeout, active, state);
  modport slave  (input  start, move_done, game_over,
                  output player, secs_left, timeout, active, state);
`endif

endinterface

// File: rtl/tick_gen.sv
// Seconds prescaler: counts enabled cycles 0..TICKS_PER_SEC-1 and flags the last one.
module tick_gen #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic sec_tick
);

  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign sec_tick = enable && !clear && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/turn_scheduler.sv
// Round-robin game-turn controller with a per-turn seconds countdown.
// Optional PAUSE_EN adds a pause input that freezes the running turn.
module turn_scheduler
  import turn_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TURN_SECS     = 15,
  parameter int NUM_PLAYERS   = 2
) (
  input  logic             clk,
  input  logic             reset,
  turn_scheduler_if.slave  bus
);

  localparam int PW = player_w(NUM_PLAYERS);
  localparam int SW = secs_w(TURN_SECS);
  localparam logic [SW-1:0] SECS_INIT   = SW'(TURN_SECS);
  localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);

  turn_state_t   state_q, state_d;
  logic [PW-1:0] player_q, player_d;
  logic [SW-1:0] secs_q, secs_d;
  logic          timeout_q, timeout_d;
  logic          active_q, active_d;
  logic          pause_w;
  logic          sec_tick;

`ifdef PAUSE_EN
  assign pause_w = bus.pause;
`else
  assign pause_w = 1'b0;
`endif

  // The prescaler is held at zero outside PLAY, so every turn starts a fresh second.
  tick_gen #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q != PLAY),
    .enable   ((state_q == PLAY) && !pause_w),
    .sec_tick (sec_tick)
  );

  always_comb begin
    state_d   = state_q;
    player_d  = player_q;
    secs_d    = secs_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = PLAY;
          player_d = '0;
          secs_d   = SECS_INIT;
        end
      end
      PLAY: begin
        // game_over beats move_done beats expiry; pause masks the latter two.
        if (bus.game_over) begin
          state_d = DONE;
        end else if (bus.move_done && !pause_w) begin
          state_d = SWITCH;
        end else if (sec_tick) begin
          if (secs_q <= SW'(1)) begin
            state_d   = SWITCH;
            secs_d    = '0;
            timeout_d = 1'b1;
          end else begin
            secs_d = secs_q - SW'(1);
          end
        end
      end
      SWITCH: begin
        if (bus.game_over) begin
          state_d = DONE;
        end else begin
          state_d  = PLAY;
          player_d = (player_q == LAST_PLAYER) ? '0 : player_q + PW'(1);
          secs_d   = SECS_INIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    active_d = (state_d == PLAY) || (state_d == SWITCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      player_q  <= '0;
      secs_q    <= SECS_INIT;
      timeout_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      player_q  <= player_d;
      secs_q    <= secs_d;
      timeout_q <= timeout_d;
      active_q  <= active_d;
    end
  end

  assign bus.player    = player_q;
  assign bus.secs_left = secs_q;
  assign bus.timeout   = timeout_q;
  assign bus.active    = active_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Randomized + directed bench for turn_scheduler with a queue-based scoreboard.
module tb_turn_scheduler;
  import turn_pkg::*;

  localparam int TICKS = 4;
  localparam int TURN  = 3;
  localparam int NPL   = 2;
  localparam int PW    = 1;
  localparam int SW    = 2;
  localparam int W     = PW + SW + 2;

  localparam int M_IDLE = 0, M_PLAY = 1, M_SWITCH = 2, M_DONE = 3;

  logic clk;
  logic reset;
  logic pause_i;

  turn_scheduler_if #(.PW(PW), .SW(SW)) bus ();

`ifdef PAUSE_EN
  assign bus.pause = pause_i;
`endif

  turn_scheduler #(
    .TICKS_PER_SEC (TICKS),
    .TURN_SECS     (TURN),
    .NUM_PLAYERS   (NPL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Turn time is tracked as elapsed unpaused PLAY cycles; seconds shown are
  // TURN minus whole elapsed seconds, and the turn expires at TURN*TICKS cycles.
  int m_mode    = M_IDLE;
  int m_player  = 0;
  int m_secs    = TURN;
  int m_elapsed = 0;
  bit m_timeout = 0;
  bit m_active  = 0;

  task automatic model_step(input bit rst, input bit st, input bit md,
                            input bit go, input bit ps);
    m_timeout = 0;
    if (rst) begin
      m_mode = M_IDLE; m_player = 0; m_secs = TURN; m_elapsed = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: begin
          if (st) begin
            m_mode = M_PLAY; m_player = 0; m_secs = TURN; m_elapsed = 0;
          end
        end
        M_PLAY: begin
          if (go) m_mode = M_DONE;
          else if (md && !ps) m_mode = M_SWITCH;
          else if (!ps) begin
            m_elapsed++;
            if (m_elapsed == TURN * TICKS) begin
              m_mode = M_SWITCH; m_secs = 0; m_timeout = 1;
            end else begin
              m_secs = TURN - m_elapsed / TICKS;
            end
          end
        end
        default: begin
          if (go) m_mode = M_DONE;
          else begin
            m_mode = M_PLAY; m_player = (m_player + 1) % NPL;
            m_secs = TURN; m_elapsed = 0;
          end
        end
      endcase
    end
    m_active = (m_mode == M_PLAY) || (m_mode == M_SWITCH);
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      exp_v = exp_q.pop_front();
      act_v = {bus.player, bus.secs_left, bus.timeout, bus.active};
      n_checks++;
      if (act_v === exp_v) n_pass++;
      else
        $display("FAIL outputs t=%0t state=%0d got player=%0d secs=%0d timeout=%0b active=%0b, expected player=%0d secs=%0d timeout=%0b active=%0b",
                 $time, bus.state, act_v[W-1 -: PW], act_v[SW+1:2], act_v[1], act_v[0],
                 exp_v[W-1 -: PW], exp_v[SW+1:2], exp_v[1], exp_v[0]);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit st, input bit md,
                       input bit go, input bit ps);
    bit ps_eff;
`ifdef PAUSE_EN
    ps_eff = ps;
`else
    ps_eff = 1'b0;
`endif
    @(negedge clk);
    reset = rst; bus.start = st; bus.move_done = md; bus.game_over = go;
    pause_i = ps_eff;
    model_step(rst, st, md, go, ps_eff);
    exp_q.push_back({PW'(m_player), SW'(m_secs), m_timeout, m_active});
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; pause_i = 1'b0;
    bus.start = 1'b0; bus.move_done = 1'b0; bus.game_over = 1'b0;

    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    idle(10);

    // Full timeout of player 0, then player 1 takes over.
    drive(0, 1, 0, 0, 0);
    idle(14);

    // Player 1 finishes early, wraps to player 0; player 0 finishes too.
    idle(4);
    drive(0, 0, 1, 0, 0);
    idle(1);
    idle(6);
    drive(0, 0, 1, 0, 0);

    // move_done coincident with the expiring tick.
    idle(1);
    idle(11);
    drive(0, 0, 1, 0, 0);

    // game_over with move_done, then restart from DONE.
    idle(1);
    idle(3);
    drive(0, 0, 1, 1, 0);
    idle(3);
    drive(0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0);

    // Pause at secs_left=2, then resume.
    idle(5);
    for (int i = 0; i < 20; i++) drive(0, 0, (i == 7), 0, 1);
    idle(10);

    // Reset in the middle of a turn.
    drive(1, 0, 0, 0, 0);
    idle(3);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) == 0);
    end

    idle(2);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain left=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
